mem_stage_mo: RTL and testbench
===============================

Name: mem_stage_mo

Overview:
- Parametrised successor of the single-entry MEM stage.
- Holds up to DEPTH in-flight instructions between EX and WB, so several data-SRAM loads can be outstanding at once.
- Matches in-order data_ok responses to queued entries and formats load data (byte/half/word, optional lwl/lwr) with per-byte GPR write strobes.
- Discards stale responses after a WB exception/eret flush, and supplies forward/block information to ID.

Parameters:
- DEPTH, 4, instruction queue entries (power of two, >=2).
- MAX_OUTST, 4, maximum data-SRAM requests outstanding (accepted, data_ok not yet returned).
- CNT_W, 3, width of the outstanding/discard counters; must hold MAX_OUTST.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- es_to_ms_valid  in  1  EX has an instruction
- ms_allowin  out  1  queue can accept (not full, or head leaving this cycle)
- es_pc  in  32  instruction PC
- es_exe_result  in  32  ALU result / load address
- es_dest  in  5  destination GPR
- es_gr_we  in  1  writes GPR
- es_load_op  in  3  0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwl, 7 lwr
- es_wait_mem  in  1  instruction owns a data_ok response
- es_req_fire  in  1  data-SRAM request accepted this cycle (req&&addr_ok)
- ms_req_allow  out  1  EX may issue a new request
- data_sram_data_ok  in  1  response strobe
- data_sram_rdata  in  32  response data
- ws_allowin  in  1  WB accepts
- ms_to_ws_valid  out  1  head complete and valid
- ms_pc  out  32
- ms_dest  out  5
- ms_final_result  out  32
- ms_gr_strb  out  4
- ws_flush  in  1  ws_ex or ws_eret
- id_rs  in  5  ID source query
- id_rt  in  5  ID source query
- rs_fwd_valid  out  1
- rt_fwd_valid  out  1
- rs_blk  out  1
- rt_blk  out  1
- fwd_data  out  32  = ms_final_result
- fwd_strb  out  4  = ms_gr_strb when forwarding

Behaviour:
- Reset (async, resetn=0): queue empty, wr/rd pointers 0, all entry valid/done flags 0, pending=0, discard=0.
  - Outputs at reset: ms_to_ws_valid=0, ms_allowin=1, ms_req_allow=1, all fwd/blk outputs 0.
- Enqueue on es_to_ms_valid && ms_allowin && !ws_flush.
  - Entry stores pc, exe_result, dest, gr_we, load_op, wait_mem; done is cleared.
- Dequeue head on ms_to_ws_valid && ws_allowin. Enqueue and dequeue may occur in the same cycle, including when the queue is full.
- Pointers wrap modulo DEPTH. Full/empty are tracked with a count or an extra pointer bit.
- Head completion:
  - ms_to_ws_valid = head valid && (!wait_mem || done) && !ws_flush.
  - Outputs are combinational from the head entry.
- pending counter:
  - +1 on es_req_fire, -1 on data_sram_data_ok; both in one cycle leaves it unchanged.
  - ms_req_allow = pending < MAX_OUTST.
- Response routing when data_sram_data_ok:
  - If discard>0: discard decrements and the data is dropped.
  - Otherwise the data is written into the oldest entry with wait_mem && !done, and that entry's done is set.
  - A data_ok with no such entry and discard=0 is a protocol error; it is ignored.
  - Completion is available to WB the cycle after data_ok; there is no bypass of rdata.
- Flush (ws_flush=1):
  - All entries are invalidated next cycle and nothing is enqueued.
  - discard <= pending_next, i.e. pending after this cycle's req_fire/data_ok updates, excluding any data_ok already dropped this cycle.
- Load formatting (addr = exe_result[1:0]):
  - lb/lbu: byte at addr, sign- or zero-extended.
  - lh/lhu: half at addr[1], sign- or zero-extended.
  - lw: word.
  - lwl: strb 1000/1100/1110/1111 for addr 0..3; data left-shifted by (3-addr) bytes.
  - lwr: strb 1111/0111/0011/0001 for addr 0..3; data right-shifted by addr bytes.
  - Non-load entries: result = exe_result, strb = {4{gr_we}}.
- Forward/block per query r (rs, rt):
  - Find the youngest valid entry with gr_we && dest==r && r!=0.
  - If that entry is the head and it is complete: fwd_valid=1, blk=0.
  - If it is not complete or not the head: blk=1.
  - No match: both 0.
  - During ws_flush, all fwd_valid/blk outputs are 0.

Optional Feature:
- MEM_UNALIGNED_EN defined: lwl/lwr formatting and partial strobes as specified above.
- Undefined: load_op 6/7 are treated as lw (full word, strb 1111), and the left/right shifters are not built.

Test Plan:
- Back-to-back lw x3 to addr 0x100/0x104/0x108, data_ok 3 cycles later each with 0x11,0x22,0x33 -> WB receives them in order, strb 1111; pending peaks at 3.
- MAX_OUTST=4 with 4 requests fired and no data_ok -> ms_req_allow=0 until the first data_ok, then 1.
- 2 loads outstanding, ws_flush asserted -> queue empty next cycle, discard=2; next 2 data_ok are dropped; a new lw after the flush gets the 3rd response, 0xCAFEF00D.
- lb addr 0x3, rdata 0x80FF_0000 -> result 0xFFFF_FF80; lbu -> 0x0000_0080; lh addr 2 -> 0xFFFF_80FF.
- MEM_UNALIGNED_EN, lwl addr 1, rdata 0x44332211 -> result 0x22110000, strb 1100; lwr addr 2 -> 0x00004433, strb 0011.
- Head lw to r5 not done, ALU op to r5 behind it: id_rs=5 -> rs_blk=1. After both complete and the lw retires: rs_fwd_valid=1 with the ALU value.

Source files
------------

// File: rtl/mem_stage_mo.sv
// mem_stage_mo: multi-outstanding MEM stage sitting between EX and WB.
// Queues up to DEPTH instructions. In-order data_ok responses are matched to
// the oldest queued load still waiting for data. The head entry's load data is
// formatted, with per-byte GPR write strobes, for WB and for forwarding to ID.
// Responses that belong to instructions killed by a WB flush are counted and
// dropped.
// Optional feature: define MEM_UNALIGNED_EN to build lwl/lwr formatting with
// partial strobes. Without it, lwl/lwr behave as lw.
module mem_stage_mo #(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic [31:0] es_exe_result,
  input  logic [4:0]  es_dest,
  input  logic        es_gr_we,
  input  logic [2:0]  es_load_op,
  input  logic        es_wait_mem,
  input  logic        es_req_fire,
  output logic        ms_req_allow,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [4:0]  ms_dest,
  output logic [31:0] ms_final_result,
  output logic [3:0]  ms_gr_strb,
  input  logic        ws_flush,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        rs_fwd_valid,
  output logic        rt_fwd_valid,
  output logic        rs_blk,
  output logic        rt_blk,
  output logic [31:0] fwd_data,
  output logic [3:0]  fwd_strb
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LW  = 3'd5;
  localparam logic [2:0] LD_LWL = 3'd6;
  localparam logic [2:0] LD_LWR = 3'd7;

  // Per-entry payload
  logic [31:0] r_pc       [DEPTH];
  logic [31:0] r_res      [DEPTH];
  logic [31:0] r_data     [DEPTH];
  logic [4:0]  r_dest     [DEPTH];
  logic [2:0]  r_load_op  [DEPTH];
  logic [DEPTH-1:0] r_gr_we;
  logic [DEPTH-1:0] r_wait_mem;

  // Per-entry control and queue bookkeeping
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] r_discard;

  logic [PTR_W-1:0] w_age_idx [DEPTH];
  logic             w_head_cmpl;
  logic             w_full;
  logic             w_enq;
  logic             w_deq;
  logic             w_tgt_hit;
  logic [PTR_W-1:0] w_tgt_idx;
  logic             w_resp_drop;
  logic             w_resp_wr;
  logic             w_ok_dec;
  logic [CNT_W-1:0] w_pending_next;
  logic [31:0]      w_ld_data;
  logic [1:0]       w_addr;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_result;
  logic [3:0]       w_strb;
  logic             w_rs_hit;
  logic             w_rs_head;
  logic             w_rt_hit;
  logic             w_rt_head;

  // w_age_idx[k] is the slot holding the k-th oldest entry (0 = head)
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign w_age_idx[g] = r_rd_ptr + PTR_W'(g);
  end

  assign w_head_cmpl    = r_valid[r_rd_ptr] && (!r_wait_mem[r_rd_ptr] || r_done[r_rd_ptr]);
  assign ms_to_ws_valid = w_head_cmpl && !ws_flush;
  assign w_deq          = ms_to_ws_valid && ws_allowin;
  assign w_full         = (r_count == OCC_W'(DEPTH));
  assign ms_allowin     = !w_full || w_deq;
  assign w_enq          = es_to_ms_valid && ms_allowin && !ws_flush;

  assign w_resp_drop    = data_sram_data_ok && (r_discard != '0);
  assign w_resp_wr      = data_sram_data_ok && !w_resp_drop && w_tgt_hit;
  assign w_ok_dec       = data_sram_data_ok && (r_pending != '0);
  assign w_pending_next = r_pending + CNT_W'(es_req_fire) - CNT_W'(w_ok_dec);
  assign ms_req_allow   = (r_pending < CNT_W'(MAX_OUTST));

  // Find the oldest queued entry that still waits for its data_ok response
  always_comb begin
    w_tgt_hit = 1'b0;
    w_tgt_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_tgt_hit && r_valid[w_age_idx[k]] && r_wait_mem[w_age_idx[k]] &&
          !r_done[w_age_idx[k]]) begin
        w_tgt_hit = 1'b1;
        w_tgt_idx = w_age_idx[k];
      end
    end
  end

  // Queue pointers, occupancy and per-entry valid/done flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_done   <= '0;
    end else if (ws_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_deq) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      if (w_resp_wr) begin
        r_done[w_tgt_idx] <= 1'b1;
      end
      if (w_enq) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_done[r_wr_ptr]  <= 1'b0;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      r_count <= r_count + OCC_W'(w_enq) - OCC_W'(w_deq);
    end
  end

  // Outstanding-request counter and count of stale responses still to drop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= '0;
      r_discard <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (ws_flush) begin
        r_discard <= w_pending_next;
      end else if (w_resp_drop) begin
        r_discard <= r_discard - CNT_W'(1);
      end
    end
  end

  // Entry payload capture on enqueue and load data capture on response
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc[r_wr_ptr]       <= es_pc;
      r_res[r_wr_ptr]      <= es_exe_result;
      r_dest[r_wr_ptr]     <= es_dest;
      r_load_op[r_wr_ptr]  <= es_load_op;
      r_gr_we[r_wr_ptr]    <= es_gr_we;
      r_wait_mem[r_wr_ptr] <= es_wait_mem;
    end
    if (w_resp_wr) begin
      r_data[w_tgt_idx] <= data_sram_rdata;
    end
  end

  // Format the head entry's load data and build its GPR byte strobes
  always_comb begin
    w_ld_data = r_data[r_rd_ptr];
    w_addr    = r_res[r_rd_ptr][1:0];
    w_byte    = w_ld_data[{w_addr, 3'b000} +: 8];
    w_half    = w_addr[1] ? w_ld_data[31:16] : w_ld_data[15:0];
    w_result  = r_res[r_rd_ptr];
    w_strb    = {4{r_gr_we[r_rd_ptr]}};
    case (r_load_op[r_rd_ptr])
      LD_LB:  w_result = {{24{w_byte[7]}}, w_byte};
      LD_LBU: w_result = {24'd0, w_byte};
      LD_LH:  w_result = {{16{w_half[15]}}, w_half};
      LD_LHU: w_result = {16'd0, w_half};
      LD_LW:  w_result = w_ld_data;
`ifdef MEM_UNALIGNED_EN
      LD_LWL: begin
        w_result = w_ld_data << {~w_addr, 3'b000};
        w_strb   = {4{r_gr_we[r_rd_ptr]}} & (4'b1111 << ~w_addr);
      end
      LD_LWR: begin
        w_result = w_ld_data >> {w_addr, 3'b000};
        w_strb   = {4{r_gr_we[r_rd_ptr]}} & (4'b1111 >> w_addr);
      end
`else
      LD_LWL, LD_LWR: w_result = w_ld_data;
`endif
      default: w_result = r_res[r_rd_ptr];
    endcase
  end

  // Locate the youngest queued writer of each ID source register
  always_comb begin
    w_rs_hit  = 1'b0;
    w_rs_head = 1'b0;
    w_rt_hit  = 1'b0;
    w_rt_head = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_valid[w_age_idx[k]] && r_gr_we[w_age_idx[k]] && (id_rs != 5'd0) &&
          (r_dest[w_age_idx[k]] == id_rs)) begin
        w_rs_hit  = 1'b1;
        w_rs_head = (k == 0);
      end
      if (r_valid[w_age_idx[k]] && r_gr_we[w_age_idx[k]] && (id_rt != 5'd0) &&
          (r_dest[w_age_idx[k]] == id_rt)) begin
        w_rt_hit  = 1'b1;
        w_rt_head = (k == 0);
      end
    end
  end

  assign rs_fwd_valid = w_rs_hit && w_rs_head && w_head_cmpl && !ws_flush;
  assign rt_fwd_valid = w_rt_hit && w_rt_head && w_head_cmpl && !ws_flush;
  assign rs_blk       = w_rs_hit && !(w_rs_head && w_head_cmpl) && !ws_flush;
  assign rt_blk       = w_rt_hit && !(w_rt_head && w_head_cmpl) && !ws_flush;

  assign ms_pc           = r_pc[r_rd_ptr];
  assign ms_dest         = r_dest[r_rd_ptr];
  assign ms_final_result = w_result;
  assign ms_gr_strb      = w_strb;
  assign fwd_data        = w_result;
  assign fwd_strb        = (rs_fwd_valid || rt_fwd_valid) ? w_strb : 4'b0000;

endmodule

// File: tb/tb_mem_stage_mo.sv
// tb_mem_stage_mo: directed self-checking bench for mem_stage_mo.
// Walks through reset, in-order load completion, the outstanding-request
// limit, flush with stale-response discard, load formatting and ID
// forward/block decisions, with hand-computed expectations throughout.
module tb_mem_stage_mo;

  logic        clk;
  logic        resetn;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [31:0] es_exe_result;
  logic [4:0]  es_dest;
  logic        es_gr_we;
  logic [2:0]  es_load_op;
  logic        es_wait_mem;
  logic        es_req_fire;
  logic        ms_req_allow;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic [31:0] ms_final_result;
  logic [3:0]  ms_gr_strb;
  logic        ws_flush;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        rs_fwd_valid;
  logic        rt_fwd_valid;
  logic        rs_blk;
  logic        rt_blk;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_strb;

  int checks = 0;
  int errors = 0;

  mem_stage_mo dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_exe_result(es_exe_result), .es_dest(es_dest),
    .es_gr_we(es_gr_we), .es_load_op(es_load_op), .es_wait_mem(es_wait_mem),
    .es_req_fire(es_req_fire), .ms_req_allow(ms_req_allow),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_pc(ms_pc), .ms_dest(ms_dest), .ms_final_result(ms_final_result),
    .ms_gr_strb(ms_gr_strb), .ws_flush(ws_flush),
    .id_rs(id_rs), .id_rt(id_rt),
    .rs_fwd_valid(rs_fwd_valid), .rt_fwd_valid(rt_fwd_valid),
    .rs_blk(rs_blk), .rt_blk(rt_blk),
    .fwd_data(fwd_data), .fwd_strb(fwd_strb)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a runaway simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Clock in whatever inputs are currently driven, then move off the edge
  task automatic applyStimulus();
    @(posedge clk);
    #2;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one instruction from EX into the queue
  task automatic driveEx(input logic [31:0] pc, input logic [31:0] res,
                         input logic [4:0] dest, input logic [2:0] op,
                         input logic waitMem, input logic fire);
    es_to_ms_valid = 1'b1;
    es_pc          = pc;
    es_exe_result  = res;
    es_dest        = dest;
    es_gr_we       = 1'b1;
    es_load_op     = op;
    es_wait_mem    = waitMem;
    es_req_fire    = fire;
  endtask

  task automatic idleEx();
    es_to_ms_valid = 1'b0;
    es_req_fire    = 1'b0;
  endtask

  // Single load: enqueue, respond, check formatting, retire to WB
  task automatic runLoad(input string tag, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] expRes, input logic [3:0] expStrb);
    ws_allowin = 1'b0;
    driveEx(32'h4000, addr, 5'd10, op, 1'b1, 1'b1);
    applyStimulus();
    idleEx();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    applyStimulus();
    data_sram_data_ok = 1'b0;
    #1;
    checkOutput({tag, "_valid"}, 32'(ms_to_ws_valid), 32'd1);
    checkOutput({tag, "_result"}, ms_final_result, expRes);
    checkOutput({tag, "_strb"}, 32'(ms_gr_strb), 32'(expStrb));
    ws_allowin = 1'b1;
    applyStimulus();
    ws_allowin = 1'b0;
  endtask

  // Directed sequence
  initial begin
    resetn = 1'b0;
    es_to_ms_valid = 1'b0; es_pc = '0; es_exe_result = '0; es_dest = '0;
    es_gr_we = 1'b0; es_load_op = '0; es_wait_mem = 1'b0; es_req_fire = 1'b0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_allowin = 1'b0;
    ws_flush = 1'b0; id_rs = 5'd0; id_rt = 5'd0;

    applyStimulus();
    applyStimulus();
    checkOutput("rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    checkOutput("rst_allowin", 32'(ms_allowin), 32'd1);
    checkOutput("rst_req_allow", 32'(ms_req_allow), 32'd1);
    checkOutput("rst_fwd_blk", 32'({rs_fwd_valid, rt_fwd_valid, rs_blk, rt_blk}), 32'd0);
    resetn = 1'b1;
    applyStimulus();

    // Three back-to-back word loads, returned in order
    driveEx(32'h1000, 32'h100, 5'd3, 3'd5, 1'b1, 1'b1);
    applyStimulus();
    driveEx(32'h1004, 32'h104, 5'd4, 3'd5, 1'b1, 1'b1);
    applyStimulus();
    driveEx(32'h1008, 32'h108, 5'd6, 3'd5, 1'b1, 1'b1);
    applyStimulus();
    idleEx();
    #1;
    checkOutput("lw3_req_allow", 32'(ms_req_allow), 32'd1);
    checkOutput("lw3_wait_valid", 32'(ms_to_ws_valid), 32'd0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11; ws_allowin = 1'b1;
    applyStimulus();
    data_sram_rdata = 32'h22;
    #1;
    checkOutput("lw3_a_valid", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("lw3_a_result", ms_final_result, 32'h11);
    checkOutput("lw3_a_strb", 32'(ms_gr_strb), 32'hF);
    checkOutput("lw3_a_pc", ms_pc, 32'h1000);
    checkOutput("lw3_a_dest", 32'(ms_dest), 32'd3);
    applyStimulus();
    data_sram_rdata = 32'h33;
    #1;
    checkOutput("lw3_b_result", ms_final_result, 32'h22);
    checkOutput("lw3_b_pc", ms_pc, 32'h1004);
    applyStimulus();
    data_sram_data_ok = 1'b0;
    #1;
    checkOutput("lw3_c_result", ms_final_result, 32'h33);
    checkOutput("lw3_c_dest", 32'(ms_dest), 32'd6);
    applyStimulus();
    ws_allowin = 1'b0;
    #1;
    checkOutput("lw3_empty", 32'(ms_to_ws_valid), 32'd0);

    // Four outstanding requests hit the limit and fill the queue
    for (int i = 0; i < 4; i++) begin
      driveEx(32'h2000 + 32'(4 * i), 32'h140 + 32'(4 * i), 5'd7, 3'd5, 1'b1, 1'b1);
      applyStimulus();
    end
    idleEx();
    #1;
    checkOutput("max_req_allow_lo", 32'(ms_req_allow), 32'd0);
    checkOutput("max_full_allowin", 32'(ms_allowin), 32'd0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hA0;
    applyStimulus();
    data_sram_data_ok = 1'b0;
    #1;
    checkOutput("max_req_allow_hi", 32'(ms_req_allow), 32'd1);
    checkOutput("max_head_result", ms_final_result, 32'hA0);
    checkOutput("max_full_leave_allowin", 32'(ms_allowin), 32'd0);
    ws_allowin = 1'b1;
    #1;
    checkOutput("max_full_leave_allowin2", 32'(ms_allowin), 32'd1);
    for (int i = 1; i < 4; i++) begin
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hA0 + 32'(i);
      applyStimulus();
    end
    data_sram_data_ok = 1'b0;
    #1;
    checkOutput("max_last_result", ms_final_result, 32'hA3);
    checkOutput("max_last_pc", ms_pc, 32'h200C);
    applyStimulus();
    ws_allowin = 1'b0;
    #1;
    checkOutput("max_drained", 32'(ms_to_ws_valid), 32'd0);

    // Flush with two loads outstanding; stale responses are dropped
    driveEx(32'h2800, 32'h180, 5'd8, 3'd5, 1'b1, 1'b1);
    applyStimulus();
    driveEx(32'h2804, 32'h184, 5'd8, 3'd5, 1'b1, 1'b1);
    applyStimulus();
    idleEx();
    id_rs = 5'd8;
    #1;
    checkOutput("fl_pre_blk", 32'(rs_blk), 32'd1);
    ws_flush = 1'b1;
    #1;
    checkOutput("fl_blk_masked", 32'(rs_blk), 32'd0);
    checkOutput("fl_valid_masked", 32'(ms_to_ws_valid), 32'd0);
    applyStimulus();
    ws_flush = 1'b0;
    #1;
    checkOutput("fl_empty_allowin", 32'(ms_allowin), 32'd1);
    checkOutput("fl_empty_blk", 32'(rs_blk), 32'd0);
    id_rs = 5'd0;
    driveEx(32'h3000, 32'h200, 5'd9, 3'd5, 1'b1, 1'b1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD0001;
    applyStimulus();
    idleEx();
    data_sram_rdata = 32'hDEAD0002;
    applyStimulus();
    data_sram_rdata = 32'hCAFEF00D;
    #1;
    checkOutput("fl_new_not_done", 32'(ms_to_ws_valid), 32'd0);
    applyStimulus();
    data_sram_data_ok = 1'b0;
    #1;
    checkOutput("fl_new_valid", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("fl_new_result", ms_final_result, 32'hCAFEF00D);
    checkOutput("fl_new_pc", ms_pc, 32'h3000);
    ws_allowin = 1'b1;
    applyStimulus();
    ws_allowin = 1'b0;

    // Load formatting
    runLoad("lb", 3'd1, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80, 4'b1111);
    runLoad("lbu", 3'd2, 32'h103, 32'h80FF_0000, 32'h0000_0080, 4'b1111);
    runLoad("lh", 3'd3, 32'h102, 32'h80FF_0000, 32'hFFFF_80FF, 4'b1111);
    runLoad("lhu", 3'd4, 32'h102, 32'h80FF_0000, 32'h0000_80FF, 4'b1111);
    runLoad("lb0", 3'd1, 32'h100, 32'h1234_5678, 32'h0000_0078, 4'b1111);
`ifdef MEM_UNALIGNED_EN
    runLoad("lwl", 3'd6, 32'h101, 32'h4433_2211, 32'h2211_0000, 4'b1100);
    runLoad("lwr", 3'd7, 32'h102, 32'h4433_2211, 32'h0000_4433, 4'b0011);
`else
    runLoad("lwl", 3'd6, 32'h101, 32'h4433_2211, 32'h4433_2211, 4'b1111);
    runLoad("lwr", 3'd7, 32'h102, 32'h4433_2211, 32'h4433_2211, 4'b1111);
`endif

    // Forward/block: pending lw to r5 with an ALU op to r5 behind it
    driveEx(32'h5000, 32'h300, 5'd5, 3'd5, 1'b1, 1'b1);
    applyStimulus();
    driveEx(32'h5004, 32'h1234_5678, 5'd5, 3'd0, 1'b0, 1'b0);
    applyStimulus();
    idleEx();
    id_rs = 5'd5; id_rt = 5'd3;
    #1;
    checkOutput("fw_rs_blk", 32'(rs_blk), 32'd1);
    checkOutput("fw_rs_fwd0", 32'(rs_fwd_valid), 32'd0);
    checkOutput("fw_rt_nomatch", 32'({rt_blk, rt_fwd_valid}), 32'd0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55;
    applyStimulus();
    data_sram_data_ok = 1'b0;
    #1;
    checkOutput("fw_not_head_blk", 32'(rs_blk), 32'd1);
    checkOutput("fw_lw_result", ms_final_result, 32'h55);
    ws_allowin = 1'b1;
    applyStimulus();
    ws_allowin = 1'b0;
    id_rt = 5'd5;
    #1;
    checkOutput("fw_rs_fwd", 32'(rs_fwd_valid), 32'd1);
    checkOutput("fw_rs_blk0", 32'(rs_blk), 32'd0);
    checkOutput("fw_rt_fwd", 32'(rt_fwd_valid), 32'd1);
    checkOutput("fw_data", fwd_data, 32'h1234_5678);
    checkOutput("fw_strb", 32'(fwd_strb), 32'hF);
    id_rs = 5'd0;
    #1;
    checkOutput("fw_r0_ignored", 32'({rs_fwd_valid, rs_blk}), 32'd0);
    id_rt = 5'd0;
    ws_allowin = 1'b1;
    applyStimulus();
    ws_allowin = 1'b0;
    #1;
    checkOutput("fw_drained", 32'(ms_to_ws_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
